// File: rtl/fc_ctrl_pkg.sv
// Shared definitions for the FC-layer sequencer: state encoding, default
// geometry of the binary feature vector and the class-score bus.
package fc_ctrl_pkg;

  localparam int INPUT_NUM_DEF  = 400;
  localparam int LANES_DEF      = 16;
  localparam int OUTPUT_NUM_DEF = 10;
  localparam int OUT_W_DEF      = 9;
  localparam int BEATS_DEF      = INPUT_NUM_DEF / LANES_DEF;

  localparam int ADDR_W  = 5;
  localparam int CLASS_W = 4;
  localparam logic [CLASS_W-1:0] CLASS_ERR = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT,
    ST_ARGMAX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fc_argmax_step.sv
// One compare-select step of the running signed argmax; a strict greater-than
// keeps the earlier (lower) index on ties.
module fc_argmax_step
  import fc_ctrl_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int IDX_W = CLASS_W
) (
  input  logic signed [OUT_W-1:0] best_in,
  input  logic        [IDX_W-1:0] idx_in,
  input  logic signed [OUT_W-1:0] cand,
  input  logic        [IDX_W-1:0] cand_idx,
  output logic signed [OUT_W-1:0] best_out,
  output logic        [IDX_W-1:0] idx_out
);

  always_comb begin
    best_out = best_in;
    idx_out  = idx_in;
    if (cand > best_in) begin
      best_out = cand;
      idx_out  = cand_idx;
    end
  end

endmodule

// File: rtl/fc_ctrl.sv
// Streams a buffered binary feature vector into the FC layer, waits for its
// class scores (with timeout) and reports the winning class via signed argmax.
module fc_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int INPUT_NUM  = INPUT_NUM_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int OUTPUT_NUM = OUTPUT_NUM_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [LANES-1:0]            wr_data,
  input  logic                        start,
  output logic                        fc_valid_in,
  output logic [LANES-1:0]            fc_pixel,
  input  logic                        fc_valid_out,
  input  logic [OUTPUT_NUM*OUT_W-1:0] fc_scores,
  output logic                        busy,
  output logic                        done,
  output logic [CLASS_W-1:0]          class_out,
  output logic [OUT_W-1:0]            max_score,
  output logic                        timeout_err
);

  localparam int BEATS = INPUT_NUM / LANES;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0]  BEATS_A  = ADDR_W'(BEATS);
  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(OUTPUT_NUM - 1);
  localparam logic [TMO_W-1:0]   TMO_MAX  = TMO_W'(TIMEOUT);

  logic [LANES-1:0] feat_q [BEATS];

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         beat_q, beat_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [CLASS_W-1:0]        arg_q, arg_d;
  logic signed [OUT_W-1:0]   score_q [OUTPUT_NUM];
  logic signed [OUT_W-1:0]   score_d [OUTPUT_NUM];
  logic signed [OUT_W-1:0]   best_q, best_d, step_best;
  logic [CLASS_W-1:0]        idx_q, idx_d, step_idx;
  logic                      fc_valid_in_q, fc_valid_in_d;
  logic [LANES-1:0]          fc_pixel_q, fc_pixel_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [CLASS_W-1:0]        class_q, class_d;
  logic [OUT_W-1:0]          max_q, max_d;
  logic                      tmo_err_q, tmo_err_d;

  // Buffer is frozen while a run is in flight so the stream stays coherent.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q && (wr_addr < BEATS_A)) begin
      feat_q[wr_addr] <= wr_data;
    end
  end

  fc_argmax_step #(
    .OUT_W (OUT_W),
    .IDX_W (CLASS_W)
  ) u_step (
    .best_in  (best_q),
    .idx_in   (idx_q),
    .cand     (score_q[arg_q]),
    .cand_idx (arg_q),
    .best_out (step_best),
    .idx_out  (step_idx)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    arg_d         = arg_q;
    score_d       = score_q;
    best_d        = best_q;
    idx_d         = idx_q;
    fc_valid_in_d = 1'b0;
    fc_pixel_d    = '0;
    done_d        = 1'b0;
    class_d       = class_q;
    max_d         = max_q;
    tmo_err_d     = tmo_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_STREAM;
          fc_valid_in_d = 1'b1;
          fc_pixel_d    = feat_q[0];
          beat_d        = ADDR_W'(1);
          tmo_err_d     = 1'b0;
        end
      end
      ST_STREAM: begin
        // beat_q is the index of the next beat to present
        if (beat_q == BEATS_A) begin
          state_d = ST_WAIT;
          beat_d  = '0;
          tmo_d   = '0;
        end else begin
          fc_valid_in_d = 1'b1;
          fc_pixel_d    = feat_q[beat_q];
          beat_d        = beat_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (fc_valid_out) begin
          for (int i = 0; i < OUTPUT_NUM; i++) begin
            score_d[i] = fc_scores[i*OUT_W +: OUT_W];
          end
          state_d = ST_ARGMAX;
          arg_d   = '0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_MAX) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          class_d   = CLASS_ERR;
          max_d     = '0;
          tmo_err_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_ARGMAX: begin
        // First cycle seeds the running best with score 0, then one index per cycle.
        if (arg_q == '0) begin
          best_d = score_q[0];
          idx_d  = '0;
          arg_d  = CLASS_W'(1);
        end else begin
          best_d = step_best;
          idx_d  = step_idx;
          if (arg_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            class_d = step_idx;
            max_d   = step_best;
            arg_d   = '0;
          end else begin
            arg_d = arg_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      tmo_q         <= '0;
      arg_q         <= '0;
      for (int i = 0; i < OUTPUT_NUM; i++) score_q[i] <= '0;
      best_q        <= '0;
      idx_q         <= '0;
      fc_valid_in_q <= 1'b0;
      fc_pixel_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      class_q       <= '0;
      max_q         <= '0;
      tmo_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      arg_q         <= arg_d;
      score_q       <= score_d;
      best_q        <= best_d;
      idx_q         <= idx_d;
      fc_valid_in_q <= fc_valid_in_d;
      fc_pixel_q    <= fc_pixel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      class_q       <= class_d;
      max_q         <= max_d;
      tmo_err_q     <= tmo_err_d;
    end
  end

  assign fc_valid_in = fc_valid_in_q;
  assign fc_pixel    = fc_pixel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign class_out   = class_q;
  assign max_score   = max_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_fc_ctrl.sv
// Bench for fc_ctrl: timeline-based reference model checked every cycle, an FC
// layer responder, and directed scenarios with literal expected results.
module tb_fc_ctrl;

  localparam int BEATS = 25;
  localparam int NOUT  = 10;
  localparam int OW    = 9;
  localparam int TMO   = 255;
  localparam logic [NOUT*OW-1:0] JUNK = {{4{9'h0AA}}, 9'h0FE, {5{9'h0AA}}};

  logic                 clk = 1'b0;
  logic                 rst_n, wr_en, start;
  logic [4:0]           wr_addr;
  logic [15:0]          wr_data;
  logic                 fc_valid_in, fc_valid_out;
  logic [15:0]          fc_pixel;
  logic [NOUT*OW-1:0]   fc_scores;
  logic                 busy, done, timeout_err;
  logic [3:0]           class_out;
  logic [OW-1:0]        max_score;

  always #5 clk = ~clk;

  fc_ctrl #(
    .INPUT_NUM (400), .LANES (16), .OUTPUT_NUM (NOUT), .OUT_W (OW), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start), .fc_valid_in (fc_valid_in), .fc_pixel (fc_pixel),
    .fc_valid_out (fc_valid_out), .fc_scores (fc_scores), .busy (busy), .done (done),
    .class_out (class_out), .max_score (max_score), .timeout_err (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FC layer responder: counts beats, optionally answers after the 25th beat,
  // optionally emits a stray valid pulse mid-stream with junk scores.
  bit                 fc_respond = 1'b1;
  int                 spur_beat  = -1;
  logic [NOUT*OW-1:0] resp_bus   = '0;
  int                 fc_cnt     = 0;
  int                 fc_total   = 0;

  initial begin
    fc_valid_out = 1'b0;
    fc_scores    = JUNK;
    forever begin
      bit rsp, spr;
      @(negedge clk);
      rsp = 1'b0;
      spr = 1'b0;
      if (!rst_n) fc_cnt = 0;
      else if (fc_valid_in === 1'b1) begin
        fc_total++;
        fc_cnt++;
        if (fc_cnt == spur_beat) spr = 1'b1;
        if (fc_cnt == BEATS) begin
          fc_cnt = 0;
          rsp    = fc_respond;
        end
      end
      @(posedge clk);
      #1;
      fc_valid_out = rsp | spr;
      fc_scores    = rsp ? resp_bus : JUNK;
    end
  end

  // Reference model: tracks the run as a timeline of edges since start.
  logic [15:0] m_buf [BEATS];
  int          edge_cnt = 0;
  int          m_start_edge = 0;
  int          m_done_n = 0;
  bit          m_started = 1'b0;
  bit          m_acc = 1'b0;
  logic [3:0]  m_class = '0, m_res_class = '0;
  logic [8:0]  m_max = '0, m_res_max = '0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    int ncur, bi;
    bit running;
    logic signed [8:0] bv, c;
    if (!rst_n) begin
      m_started = 1'b0;
      m_acc     = 1'b0;
      m_class   = '0;
      m_max     = '0;
      m_err     = 1'b0;
    end else begin
      ncur    = edge_cnt - m_start_edge + 1;
      running = m_started && (ncur <= m_done_n);
      if (wr_en && !running && (wr_addr < 5'd25)) m_buf[wr_addr] = wr_data;
      if (running && !m_acc && fc_valid_out && ncur >= BEATS + 1 && ncur <= BEATS + 1 + TMO) begin
        m_acc    = 1'b1;
        m_done_n = ncur + NOUT + 1;
        bv = fc_scores[OW-1:0];
        bi = 0;
        for (int i = 1; i < NOUT; i++) begin
          c = fc_scores[i*OW +: OW];
          if (c > bv) begin
            bv = c;
            bi = i;
          end
        end
        m_res_class = 4'(bi);
        m_res_max   = bv;
      end
      if (start && !running) begin
        m_started    = 1'b1;
        m_start_edge = edge_cnt + 1;
        m_done_n     = BEATS + 1 + TMO + 1;
        m_acc        = 1'b0;
        m_err        = 1'b0;
      end else if (running && (ncur + 1 == m_done_n)) begin
        if (m_acc) begin
          m_class = m_res_class;
          m_max   = m_res_max;
        end else begin
          m_class = 4'hF;
          m_max   = '0;
          m_err   = 1'b1;
        end
      end
    end
    edge_cnt++;
  end

  always @(negedge clk) begin
    int n;
    bit run, act;
    logic [15:0] ep;
    if (chk_on && rst_n) begin
      n   = edge_cnt - m_start_edge + 1;
      run = m_started && (n <= m_done_n);
      act = run && (n <= BEATS);
      ep  = act ? m_buf[n-1] : 16'h0;
      chk("cyc_valid_in", fc_valid_in, act);
      chk("cyc_pixel", fc_pixel, ep);
      chk("cyc_busy", busy, run);
      chk("cyc_done", done, run && (n == m_done_n));
      chk("cyc_class", class_out, m_class);
      chk("cyc_max", max_score, m_max);
      chk("cyc_timeout_err", timeout_err, m_err);
    end
  end

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_all(input logic [8:0] v);
    for (int i = 0; i < NOUT; i++) resp_bus[i*OW +: OW] = v;
  endtask

  // Pulses start, returns edges from start to the done pulse (-1 on overrun).
  task automatic run(input int poke_at, output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == poke_at) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h0000; start = 1'b1;
      end else if (i == poke_at + 1) begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, b0, dn;
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_in", fc_valid_in, 1'b0);
    chk("rst_pixel", fc_pixel, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_class", class_out, 4'h0);
    chk("rst_max", max_score, 9'h0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // All-ones features, scores equal to their index, stray valid mid-stream
    for (int k = 0; k < BEATS; k++) wr(5'(k), 16'hFFFF);
    for (int i = 0; i < NOUT; i++) resp_bus[i*OW +: OW] = 9'(i);
    spur_beat = 5;
    b0 = fc_total;
    run(0, lat);
    spur_beat = -1;
    chk("s1_latency", lat, 37);
    chk("s1_beats", fc_total - b0, 25);
    chk("s1_class", class_out, 4'd9);
    chk("s1_max", max_score, 9'd9);

    // Distinct beat pattern, all scores tied at -16
    for (int k = 0; k < BEATS; k++) wr(5'(k), 16'(k * 16'h0123) ^ 16'h8001);
    set_all(9'h1F0);
    run(0, lat);
    chk("s2_latency", lat, 37);
    chk("s2_class", class_out, 4'd0);
    chk("s2_max", max_score, 9'h1F0);

    // Out-of-range addresses are dropped; tie between indices 3 and 7
    wr(5'd25, 16'h0000);
    wr(5'd31, 16'h0000);
    set_all(9'h100);
    resp_bus[3*OW +: OW] = 9'h0FF;
    resp_bus[7*OW +: OW] = 9'h0FF;
    run(0, lat);
    chk("s3_class", class_out, 4'd3);
    chk("s3_max", max_score, 9'h0FF);

    // FC never answers: timeout path, then a normal run clears the flag
    fc_respond = 1'b0;
    run(0, lat);
    chk("s4_latency", lat, 1 + BEATS + 256);
    chk("s4_timeout_err", timeout_err, 1'b1);
    chk("s4_class", class_out, 4'hF);
    chk("s4_max", max_score, 9'h0);
    fc_respond = 1'b1;
    set_all(9'h1FF);
    resp_bus[6*OW +: OW] = 9'h001;
    run(0, lat);
    chk("s5_timeout_err", timeout_err, 1'b0);
    chk("s5_class", class_out, 4'd6);
    chk("s5_max", max_score, 9'h001);

    // Write and start poked mid-stream must both be ignored
    set_all(9'h180);
    resp_bus[8*OW +: OW] = 9'h07F;
    b0 = fc_total;
    run(10, lat);
    chk("s6_latency", lat, 37);
    chk("s6_beats", fc_total - b0, 25);
    chk("s6_class", class_out, 4'd8);
    chk("s6_max", max_score, 9'h07F);

    // Reset during beat 12
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s7_valid_in_drop", fc_valid_in, 1'b0);
    chk("s7_pixel_drop", fc_pixel, 16'h0);
    chk("s7_busy_drop", busy, 1'b0);
    chk("s7_class_reset", class_out, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (45) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    chk("s7_no_done", dn, 0);

    // Short async reset pulse, start requested right after release
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    b0 = fc_total;
    run(0, lat);
    chk("s8_latency", lat, 37);
    chk("s8_beats", fc_total - b0, 25);
    chk("s8_class", class_out, 4'd8);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
